// File: rtl/stream_arb_2to1_pkg.sv
// rtl/stream_arb_2to1_pkg.sv - shared types and defaults for the 2:1 stream arbiter
package stream_arb_2to1_pkg;

    localparam int IN_D_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_st_t;

endpackage

// File: rtl/stream_arb_2to1_mux.sv
// rtl/stream_arb_2to1_mux.sv - 2:1 datapath mux shared by the arbiter
module stream_arb_2to1_mux #(
    parameter int W = 8
) (
    input  logic         sel_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/stream_arb_2to1.sv
// rtl/stream_arb_2to1.sv - round-robin 2:1 stream arbiter, burst lock under STREAM_ARB_LOCK_EN
module stream_arb_2to1
    import stream_arb_2to1_pkg::*;
#(
    parameter int In_d_W = IN_D_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I0_valid,
    input  logic [In_d_W-1:0] I0_data,
    input  logic              I0_last,
    output logic              I0_ready,
    input  logic              I1_valid,
    input  logic [In_d_W-1:0] I1_data,
    input  logic              I1_last,
    output logic              I1_ready,
    output logic              Y_valid,
    output logic [In_d_W-1:0] Y_data,
    output logic              Y_last,
    output logic              Y_sel,
    input  logic              Y_ready,
    output logic              busy
);

    arb_st_t           state_q, state_d;
    logic              prio_q, prio_d;
    logic              y_valid_q, y_valid_d;
    logic [In_d_W-1:0] y_data_q, y_data_d;
    logic              y_last_q, y_last_d;
    logic              y_sel_q, y_sel_d;

    logic            free;
    logic            gnt_vld;
    logic            gnt_idx;
    logic            acc;
    logic            acc_last;
    logic [In_d_W:0] mux_y;

    assign free = !y_valid_q || Y_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        case (state_q)
            LOCK0: begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b0;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
            default: begin
                if (I0_valid && I1_valid) begin
                    gnt_vld = 1'b1;
                    gnt_idx = prio_q;
                end else if (I0_valid) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b0;
                end else if (I1_valid) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b1;
                end
            end
        endcase
    end

    assign I0_ready = free && gnt_vld && !gnt_idx;
    assign I1_ready = free && gnt_vld && gnt_idx;
    assign acc      = gnt_vld && free && (gnt_idx ? I1_valid : I0_valid);

    // last travels with the data so the output register sees one mux result
    stream_arb_2to1_mux #(.W(In_d_W + 1)) u_mux (
        .sel_i (gnt_idx),
        .a_i   ({I0_last, I0_data}),
        .b_i   ({I1_last, I1_data}),
        .y_o   (mux_y)
    );

`ifdef STREAM_ARB_LOCK_EN
    assign acc_last = mux_y[In_d_W];
    assign busy     = (state_q != IDLE);
`else
    assign acc_last = 1'b1;
    assign busy     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_last_d  = y_last_q;
        y_sel_d   = y_sel_q;
        if (acc) begin
            y_valid_d = 1'b1;
            y_data_d  = mux_y[In_d_W-1:0];
            y_last_d  = mux_y[In_d_W];
            y_sel_d   = gnt_idx;
            if (acc_last) begin
                state_d = IDLE;
                prio_d  = ~gnt_idx;
            end else begin
                state_d = gnt_idx ? LOCK1 : LOCK0;
            end
        end else if (free) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_last_q  <= 1'b0;
            y_sel_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_last_q  <= y_last_d;
            y_sel_q   <= y_sel_d;
        end
    end

    assign Y_valid = y_valid_q;
    assign Y_data  = y_data_q;
    assign Y_last  = y_last_q;
    assign Y_sel   = y_sel_q;

endmodule

// File: doc/stream_arb_2to1.md
# stream_arb_2to1

Two-requester round-robin arbiter sharing one downstream datapath port between two valid/ready producers, e.g. two convolution engines feeding a single pooling or line-buffer write port. The block owns the select for the shared 2:1 data mux, drives its `sel` as a registered status output, and holds a grant for a whole burst so that feature-map rows are never interleaved. The output is one registered stage with full-throughput valid/ready back-pressure.

## Interface
- `In_d_W`, default 8: data width of each requester and the output.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion synchronous to `clk` externally.
- `I0_valid`, `I1_valid`  in  1  requester n has a beat.
- `I0_data`, `I1_data`  in  In_d_W  requester n beat.
- `I0_last`, `I1_last`  in  1  beat is last of requester n burst.
- `I0_ready`, `I1_ready`  out  1  beat of requester n accepted this cycle when valid&ready.
- `Y_valid`  out  1  output beat present.
- `Y_data`  out  In_d_W  output beat.
- `Y_last`  out  1  output beat ends a burst.
- `Y_sel`  out  1  source of the current output beat (0 = I0, 1 = I1).
- `Y_ready`  in  1  downstream accepts the output beat.
- `busy`  out  1  a burst is locked (state ≠ IDLE).

## Operation
- States: IDLE, LOCK0, LOCK1. Round-robin pointer `prio` (1 bit) names the favoured requester.
- Slot free: `free = !Y_valid || Y_ready`.
- Grant (combinational): IDLE → if both valid, `prio`; else whichever is valid; none if neither valid. LOCKn → n only.
- `In_ready = free && (grant == n)`; the non-granted requester sees ready = 0.
- Accepted beat (valid&ready on granted n): loads `Y_data/Y_last ← In_data/In_last`, `Y_sel ← n`, `Y_valid ← 1`.
- No accept while free: `Y_valid ← 0` when `Y_ready` consumed the old beat; otherwise output holds stable.
- Transitions: IDLE, accept from n with last=0 → LOCKn. Any state, accept from n with last=1 → IDLE, `prio ← ~n`. LOCKn with no accept → stays LOCKn (indefinitely; no timeout).
- A lone requester in IDLE is granted regardless of `prio`; `prio` still flips after its burst ends.
- Reset values: state IDLE, `prio` 0, `Y_valid` 0, `Y_data` 0, `Y_last` 0, `Y_sel` 0, `busy` 0. Reset mid-burst discards the in-flight output beat and the lock.

## Timing
- Latency: input accept → `Y_valid` next cycle (1 cycle).
- Throughput: one beat per cycle while `Y_ready` is held high; no bubble at burst boundaries or on switching requester.
- `Y_*` are register outputs; `In_ready` is combinational from state, `prio`, `Y_valid`, `Y_ready`, `In_valid`.
- Output held stable while `Y_valid && !Y_ready` (standard valid/ready rules); inputs need not be stable before acceptance.

## Configuration
- `STREAM_ARB_LOCK_EN` defined: burst lock as above.
- Undefined: every accepted beat is treated as last for arbitration (state never leaves IDLE, `busy` tied 0, `prio` flips after every beat → beat-level round-robin); `Y_last` still passes through unchanged.

## Structure
- Shared package: state encoding enum `arb_st_t` {IDLE, LOCK0, LOCK1} and the `In_d_W` default constant.
- The output data path instantiates the existing 2:1 mux module (selected by the combinational grant) in front of the `Y_data` register; no other sub-modules.

## Test plan
- Reset, then I0 alone sends 3 beats (0x11, 0x12, 0x13 last) with `Y_ready`=1 → `Y_data` 0x11..0x13 on cycles 1–3 after accept, `Y_sel`=0, `busy` high for 2 cycles, `prio`→1.
- Both valid continuously, 2-beat bursts each (I0: 0xA0,0xA1; I1: 0xB0,0xB1) → output order A0 A1 B0 B1 A0 A1…, no idle cycle.
- I1 raises valid mid-I0 burst → I1_ready stays 0 until I0 last accepted, then I1 granted the following cycle.
- `Y_ready`=0 for 4 cycles while a beat is held → `Y_data/Y_sel/Y_last` unchanged, both `In_ready`=0; resumes with no lost or duplicated beat.
- Assert `rst_n`=0 asynchronously in LOCK1 mid-burst → `Y_valid`=0, `busy`=0 immediately; after release, I0 granted first when both valid.
- Build without `STREAM_ARB_LOCK_EN`, both valid with 3-beat bursts → beats alternate I0,I1,I0,I1 per cycle, `busy` always 0.
